mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles waiting for mem_ack before abort (range 1..255).
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive D grants with I pending before I is forced (range 1..15).
REQ-003 Clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Rst  in  1  reset, synchronous, active-high.
REQ-005 i_req  in  1  instruction-side refill request; held until i_done.
REQ-006 i_addr  in  32  instruction-side address; stable while i_req high.
REQ-007 d_req  in  1  data-side request; held until d_done.
REQ-008 d_addr, d_wdata  in  32 each  data-side address and write data.
REQ-009 d_we  in  1  data-side write (1) / read (0).
REQ-010 i_done, d_done  out  1 each  one-cycle completion pulse to the owning requester.
REQ-011 i_rdata, d_rdata  out  32 each  read data; valid only in the done cycle, 0 otherwise.
REQ-012 i_stall, d_stall  out  1 each  combinational: req high and done low.
REQ-013 err  out  1  one-cycle pulse, coincident with done, on timeout abort.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 mem_req  out  1  backing-memory request, registered.
REQ-016 mem_addr, mem_wdata  out  32 each  registered, captured at grant.
REQ-017 mem_we  out  1  registered, captured at grant; 0 for I-side.
REQ-018 mem_rdata  in  32  backing-memory read data, valid with mem_ack.
REQ-019 mem_ack  in  1  one-cycle completion from backing memory.

Function
REQ-020 FSM states SHALL be IDLE, BUSY_I, BUSY_D, RESP.
REQ-021 IDLE: no req -> IDLE; else grant per REQ-023 and move to BUSY_I/BUSY_D, loading mem_addr/mem_we/mem_wdata and setting mem_req on the same edge.
REQ-022 Grant latency SHALL be 1 cycle: req sampled high in IDLE at edge N gives mem_req high after edge N.
REQ-023 Priority: D over I, except I SHALL win when starve_cnt == STARVE_LIMIT and i_req is high.
REQ-024 starve_cnt SHALL increment on each D grant while i_req is high, saturate at STARVE_LIMIT, and clear on any I grant or when i_req is low in IDLE.
REQ-025 BUSY_x: mem_req stays high; on mem_ack, capture mem_rdata (0 for writes), drop mem_req, go to RESP.
REQ-026 BUSY_x: a wait counter SHALL count cycles; on reaching TIMEOUT without ack, drop mem_req, go to RESP with err flagged and rdata 0.
REQ-027 RESP: pulse the owner's done (plus err if flagged) for exactly one cycle, then IDLE; a new grant SHALL NOT occur before the cycle after RESP.
REQ-028 mem_ack in IDLE or RESP SHALL be ignored.
REQ-029 A requester dropping req mid-transaction SHALL NOT abort it; done still pulses.
REQ-030 Minimum turnaround SHALL be 4 cycles per transaction: IDLE, BUSY with ack in the first cycle, RESP, IDLE.

Reset
REQ-031 Rst high at an edge SHALL force IDLE; clear starve_cnt and the wait counter; set mem_req, mem_we, done, err to 0; set mem_addr, mem_wdata, rdata to 0.
REQ-032 Reset mid-transaction SHALL abandon it with no done pulse; mem_req is low after the reset edge.

Structure
REQ-033 State encoding and default TIMEOUT/STARVE_LIMIT constants SHALL live in shared package mips_mem_pkg.
REQ-034 Timeout counting SHALL be one sub-module, wait_timer (clear/enable/expired).

Verification
REQ-035 Lone I read at 0x40, ack after 3 cycles with 0xDEADBEEF: i_done for 1 cycle with i_rdata 0xDEADBEEF; d_done stays 0; mem_we 0.
REQ-036 i_req and d_req raised in the same cycle: D served first, then I; exactly one done per transaction.
REQ-037 i_req held high with d_req re-raised after every d_done: the 5th grant goes to I (STARVE_LIMIT 4).
REQ-038 No mem_ack for 15 cycles: mem_req drops, d_done and err pulse together, d_rdata 0, FSM back to IDLE.
REQ-039 Rst asserted in BUSY_D: next cycle is IDLE with mem_req 0; no d_done; a fresh request after reset completes normally.
REQ-040 D write to 0x100 with data 0x12345678: mem_we 1 and mem_wdata 0x12345678 throughout BUSY_D; d_rdata 0 at done.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared constants for the memory port arbiter.
//   - Default TIMEOUT / STARVE_LIMIT values.
//   - FSM state encodings, kept as fixed constants so legacy code can match on them.
package mips_mem_pkg;

  localparam int unsigned TIMEOUT_DEF      = 15;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts cycles spent waiting on the backing memory.
//   clk, rst   : clock, synchronous active-high reset
//   i_clear    : return the count to zero
//   i_enable   : count this cycle
//   o_expired  : high during the TIMEOUT-th enabled cycle since the last clear
module wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory port between an instruction
// refill requester (I) and a data requester (D).
//   clk, rst                     : clock, synchronous active-high reset
//   i_req/i_addr                 : I-side request (read only)
//   d_req/d_addr/d_wdata/d_we    : D-side request
//   i_done/d_done, i_rdata/d_rdata : one-cycle completion and read data
//   i_stall/d_stall              : request pending and not completing this cycle
//   err                          : timeout abort flag, coincident with done
//   busy                         : FSM not idle
//   mem_req/mem_addr/mem_wdata/mem_we : registered backing-memory request
//   mem_rdata/mem_ack            : backing-memory response
// D has priority; I is forced after STARVE_LIMIT consecutive D grants with I waiting.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  output logic        i_done,
  output logic        d_done,
  output logic [31:0] i_rdata,
  output logic [31:0] d_rdata,
  output logic        i_stall,
  output logic        d_stall,
  output logic        err,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  r_state;
  logic        r_owner_d;
  logic [3:0]  r_starve;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_we;

  logic w_in_busy;
  logic w_expired;
  logic w_grant_i;
  logic w_resp;

  assign w_in_busy = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
  assign w_resp    = (r_state == ST_RESP);
  assign w_grant_i = i_req && (!d_req || (r_starve == LIMIT));

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (!w_in_busy),
    .i_enable (w_in_busy),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner_d   <= 1'b0;
      r_starve    <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_err   <= 1'b0;
          r_rdata <= '0;
          if (w_grant_i) begin
            r_state     <= ST_BUSY_I;
            r_owner_d   <= 1'b0;
            r_starve    <= '0;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= i_addr;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
          end else if (d_req) begin
            r_state     <= ST_BUSY_D;
            r_owner_d   <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= d_addr;
            r_mem_we    <= d_we;
            r_mem_wdata <= d_wdata;
            // I waiting behind this D grant: age it; I absent: forget history.
            if (!i_req) begin
              r_starve <= '0;
            end else if (r_starve != LIMIT) begin
              r_starve <= r_starve + 4'd1;
            end
          end else begin
            r_starve <= '0;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // An ack in the expiry cycle still counts as a normal completion.
          if (mem_ack) begin
            r_rdata   <= r_mem_we ? '0 : mem_rdata;
            r_err     <= 1'b0;
            r_mem_req <= 1'b0;
            r_state   <= ST_RESP;
          end else if (w_expired) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_err   <= 1'b0;
          r_rdata <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign i_done    = w_resp && !r_owner_d;
  assign d_done    = w_resp && r_owner_d;
  assign i_rdata   = i_done ? r_rdata : '0;
  assign d_rdata   = d_done ? r_rdata : '0;
  assign err       = w_resp && r_err;
  assign i_stall   = i_req && !i_done;
  assign d_stall   = d_req && !d_done;
  assign busy      = (r_state != ST_IDLE);
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule
